// File: rtl/demux_pkg.sv
// Shared widths and channel-select encodings for the 1-to-2 word demux.
// Optional delivery counters are enabled with macro DEMUX_COUNT_EN.
package demux_pkg;
    localparam int   DATA_W = 32;
    localparam logic SEL_A  = 1'b0;
    localparam logic SEL_B  = 1'b1;
    localparam int   CNT_W  = 16;

    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/demux_fifo.sv
// Synchronous DEPTH-entry FIFO, one cycle from push to head; refuses push when full.
// Head word is raw storage at the read pointer; callers qualify it with empty.
module demux_fifo
    import demux_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  word_t         wr_data,
    input  logic          pop,
    output word_t         rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    word_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = PW'(wr_ptr_q + 1'b1);
        if (pop_ok)  rd_ptr_d = PW'(rd_ptr_q + 1'b1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = CW'(count_q + 1'b1);
            2'b01:   count_d = CW'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/demux32_bit_1to2.sv
// Routes 32-bit words to one of two buffered channels by in_sel; latency 1 cycle.
// in_ready drops when the selected channel is full; macro DEMUX_COUNT_EN adds cnt_a/cnt_b.
module demux32_bit_1to2
    import demux_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic              out_valid_a,
    output logic              out_valid_b,
    input  logic              out_ready_a,
    input  logic              out_ready_b
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    word_t         head_a, head_b;
    logic          full_a, full_b, empty_a, empty_b;
    logic [CW-1:0] count_a, count_b;
    logic          accept, push_a, push_b, pop_a, pop_b;

    assign in_ready    = (in_sel == SEL_B) ? !full_b : !full_a;
    assign accept      = in_valid && in_ready;
    assign push_a      = accept && (in_sel == SEL_A);
    assign push_b      = accept && (in_sel == SEL_B);

    assign out_valid_a = (count_a != '0);
    assign out_valid_b = (count_b != '0);
    assign out_data_a  = empty_a ? '0 : head_a;
    assign out_data_b  = empty_b ? '0 : head_b;
    assign pop_a       = out_valid_a && out_ready_a;
    assign pop_b       = out_valid_b && out_ready_b;

    demux_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk     (Clk),
        .rst     (Reset),
        .push    (push_a),
        .wr_data (in_data),
        .pop     (pop_a),
        .rd_data (head_a),
        .full    (full_a),
        .empty   (empty_a),
        .count   (count_a)
    );

    demux_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk     (Clk),
        .rst     (Reset),
        .push    (push_b),
        .wr_data (in_data),
        .pop     (pop_b),
        .rd_data (head_b),
        .full    (full_b),
        .empty   (empty_b),
        .count   (count_b)
    );

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    // Free-running delivery counters; natural 16-bit overflow gives the wrap.
    always_comb begin
        cnt_a_d = cnt_a_q + CNT_W'(pop_a);
        cnt_b_d = cnt_b_q + CNT_W'(pop_b);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux32_bit_1to2.sv
// Directed bench for demux32_bit_1to2: vector table plus reset/order/counter sequences.
// Counter checks are compiled in only when DEMUX_COUNT_EN is defined.
module tb_demux32_bit_1to2;

    logic        Clk;
    logic        Reset;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data_a, out_data_b;
    logic        out_valid_a, out_valid_b;
    logic        out_ready_a, out_ready_b;
`ifdef DEMUX_COUNT_EN
    logic [15:0] cnt_a, cnt_b;
`endif

    int checks   = 0;
    int failures = 0;

    demux32_bit_1to2 #(.DEPTH(2)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data_a  (out_data_a),
        .out_data_b  (out_data_b),
        .out_valid_a (out_valid_a),
        .out_valid_b (out_valid_b),
        .out_ready_a (out_ready_a),
        .out_ready_b (out_ready_b)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        sel;
        logic        vld;
        logic [31:0] dat;
        logic        ra;
        logic        rb;
        logic        exp_rdy;
        logic        exp_va;
        logic [31:0] exp_da;
        logic        exp_vb;
        logic [31:0] exp_db;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic sel, input logic vld, input logic [31:0] dat,
                                input logic ra, input logic rb, input logic rdy,
                                input logic va, input logic [31:0] da,
                                input logic vb, input logic [31:0] db);
        vec_t v;
        v.sel = sel; v.vld = vld; v.dat = dat; v.ra = ra; v.rb = rb;
        v.exp_rdy = rdy; v.exp_va = va; v.exp_da = da; v.exp_vb = vb; v.exp_db = db;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // sel vld data  ra rb | rdy | va da | vb db   (outputs after the edge)
        vecs[0]  = mk(0, 1, 32'hDEADBEEF, 1, 0, 1, 1, 32'hDEADBEEF, 0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        0, 32'h0);
        vecs[2]  = mk(1, 1, 32'h1,        0, 0, 1, 0, 32'h0,        1, 32'h1);
        vecs[3]  = mk(1, 1, 32'h2,        0, 0, 1, 0, 32'h0,        1, 32'h1);
        vecs[4]  = mk(1, 1, 32'h99,       0, 0, 0, 0, 32'h0,        1, 32'h1);
        vecs[5]  = mk(0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'h1);
        vecs[6]  = mk(1, 1, 32'h55,       0, 1, 0, 0, 32'h0,        1, 32'h2);
        vecs[7]  = mk(1, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 32'h0);
        vecs[8]  = mk(0, 1, 32'hA1,       0, 0, 1, 1, 32'hA1,       0, 32'h0);
        vecs[9]  = mk(0, 1, 32'hA2,       1, 0, 1, 1, 32'hA2,       0, 32'h0);
        vecs[10] = mk(0, 1, 32'hA3,       1, 0, 1, 1, 32'hA3,       0, 32'h0);
        vecs[11] = mk(1, 1, 32'hB1,       1, 0, 1, 0, 32'h0,        1, 32'hB1);
        vecs[12] = mk(0, 0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 32'h0);

        Reset = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
        out_ready_a = 1'b0; out_ready_b = 1'b0;
        #12;
        check("rst_valid_a", {31'b0, out_valid_a}, 32'h0);
        check("rst_valid_b", {31'b0, out_valid_b}, 32'h0);
        check("rst_data_a", out_data_a, 32'h0);
        check("rst_data_b", out_data_b, 32'h0);
        check("rst_ready_sel0", {31'b0, in_ready}, 32'h1);
        in_sel = 1'b1; #1;
        check("rst_ready_sel1", {31'b0, in_ready}, 32'h1);
`ifdef DEMUX_COUNT_EN
        check("rst_cnt_a", {16'b0, cnt_a}, 32'h0);
        check("rst_cnt_b", {16'b0, cnt_b}, 32'h0);
`endif
        step();
        Reset = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            in_sel = vecs[i].sel; in_valid = vecs[i].vld; in_data = vecs[i].dat;
            out_ready_a = vecs[i].ra; out_ready_b = vecs[i].rb;
            #1;
            check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_rdy});
            step();
            check($sformatf("v%0d_valid_a", i), {31'b0, out_valid_a}, {31'b0, vecs[i].exp_va});
            check($sformatf("v%0d_data_a", i), out_data_a, vecs[i].exp_da);
            check($sformatf("v%0d_valid_b", i), {31'b0, out_valid_b}, {31'b0, vecs[i].exp_vb});
            check($sformatf("v%0d_data_b", i), out_data_b, vecs[i].exp_db);
        end

        // Alternating select: even words to A, odd words to B, both drained every cycle.
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel = i[0]; in_valid = 1'b1; in_data = 32'(i);
            #1;
            check($sformatf("alt%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
            step();
            if (i[0] == 1'b0) begin
                check($sformatf("alt%0d_valid_a", i), {31'b0, out_valid_a}, 32'h1);
                check($sformatf("alt%0d_data_a", i), out_data_a, 32'(i));
                check($sformatf("alt%0d_valid_b", i), {31'b0, out_valid_b}, 32'h0);
            end else begin
                check($sformatf("alt%0d_valid_b", i), {31'b0, out_valid_b}, 32'h1);
                check($sformatf("alt%0d_data_b", i), out_data_b, 32'(i));
                check($sformatf("alt%0d_valid_a", i), {31'b0, out_valid_a}, 32'h0);
            end
        end
        in_valid = 1'b0;
        step();
        check("alt_drain_valid_a", {31'b0, out_valid_a}, 32'h0);
        check("alt_drain_valid_b", {31'b0, out_valid_b}, 32'h0);

        // Two words parked in A, then asynchronous reset between clock edges.
        out_ready_a = 1'b0; out_ready_b = 1'b0;
        in_sel = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid_a", {31'b0, out_valid_a}, 32'h1);
        check("pre_rst_data_a", out_data_a, 32'h11);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_valid_a", {31'b0, out_valid_a}, 32'h0);
        check("async_rst_data_a", out_data_a, 32'h0);
        in_valid = 1'b1; in_data = 32'h33;
        #1;
        check("held_rst_in_ready", {31'b0, in_ready}, 32'h1);
        step();
        check("held_rst_no_accept", {31'b0, out_valid_a}, 32'h0);
        in_valid = 1'b0;
        Reset = 1'b0;
        step();
        check("post_rst_valid_a", {31'b0, out_valid_a}, 32'h0);
        check("post_rst_data_a", out_data_a, 32'h0);

`ifdef DEMUX_COUNT_EN
        // Continuous push+pop on A: 65536 edges yield 65535 pops, then one more.
        check("cnt_a_cleared", {16'b0, cnt_a}, 32'h0);
        in_sel = 1'b0; in_valid = 1'b1; in_data = 32'h77; out_ready_a = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            @(posedge Clk);
        end
        #1;
        check("cnt_a_ffff", {16'b0, cnt_a}, 32'h0000FFFF);
        check("cnt_a_ffff_valid", {31'b0, out_valid_a}, 32'h1);
        in_valid = 1'b0;
        step();
        check("cnt_a_wrap", {16'b0, cnt_a}, 32'h0);
        check("cnt_a_wrap_valid", {31'b0, out_valid_a}, 32'h0);
        check("cnt_b_idle", {16'b0, cnt_b}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
